fetch_stage: RTL and testbench

Instruction-fetch stage feeding the I-type execute datapath. It holds the program counter, issues one word-addressed read at a time to instruction memory over a req/gnt/rvalid handshake, and registers the returned instruction with its sequential next-PC into an output slot. The slot is consumed by decode/execute through a valid/ready handshake. A redirect input (taken beq/bne target) overrides the PC and squashes any fetch in flight.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_register.sv | 38 +++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam int INS_SIZE_DEF = 32;
    localparam int ADDR_W_DEF = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter: synchronous reset, redirect load, sequential increment.
module pc_register
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, single output slot.
// Optional stall counter output enabled by FETCH_STALL_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int INS_SIZE = INS_SIZE_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    output logic                im_req,
    output logic [ADDR_W-1:0]   im_addr,
    input  logic                im_gnt,
    input  logic                im_rvalid,
    input  logic [INS_SIZE-1:0] im_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                if_valid,
    output logic [INS_SIZE-1:0] if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    input  logic                id_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic                valid_q, valid_d;
    logic [INS_SIZE-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]   npc_q, npc_d;
    logic [ADDR_W-1:0]   pc_q;
    logic                pc_inc;
    logic                slot_free;
    logic                consume;
    logic                issue;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load_i    (redirect_valid),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc_q)
    );

    assign consume   = valid_q && id_ready;
    assign slot_free = !valid_q || id_ready;
    assign issue     = (state_q == REQ) && slot_free;

    assign im_req  = !rst && issue;
    assign im_addr = rst ? RESET_PC : pc_q;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q && !id_ready;
        instr_d = instr_q;
        npc_d   = npc_q;
        pc_inc  = 1'b0;
        if (redirect_valid) begin
            // Any read already granted must be drained in DROP.
            valid_d = 1'b0;
            unique case (state_q)
                REQ:     state_d = (issue && im_gnt) ? DROP : REQ;
                WAIT:    state_d = im_rvalid ? REQ : DROP;
                HOLD:    state_d = REQ;
                DROP:    state_d = im_rvalid ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (issue && im_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (im_rvalid) begin
                        valid_d = 1'b1;
                        instr_d = im_rdata;
                        npc_d   = pc_q + ADDR_W'(1);
                        pc_inc  = 1'b1;
                        state_d = id_ready ? REQ : HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        state_d = REQ;
                    end
                end
                DROP: begin
                    if (im_rvalid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            valid_q <= 1'b0;
            instr_q <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
        end
    end

    assign if_valid = valid_q;
    assign if_instr = instr_q;
    assign if_pc    = npc_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !id_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus hand-written sequences.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_gnt;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks;
    int errors;
    logic auto_mem;
    logic pend;
    logic [15:0] paddr;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_gnt         (im_gnt),
        .im_rvalid      (im_rvalid),
        .im_rdata       (im_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        if (a == 16'h0000) return 32'h2008_0005;
        return 32'h1000_0000 | {16'h0000, a};
    endfunction

    // Memory model: immediate grant, data one cycle after the grant.
    initial begin
        pend = 1'b0;
        paddr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (auto_mem) begin
                im_rvalid = pend;
                im_rdata = pend ? word_at(paddr) : 32'h0;
                pend = 1'b0;
                im_gnt = im_req;
                if (im_req) begin
                    pend = 1'b1;
                    paddr = im_addr;
                end
            end
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy,
                        input logic g, input logic rv,
                        input logic [31:0] d,
                        input logic rd, input logic [15:0] rpc);
        @(negedge clk);
        rst = r;
        id_ready = rdy;
        im_gnt = g;
        im_rvalid = rv;
        im_rdata = d;
        redirect_valid = rd;
        redirect_pc = rpc;
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        chk_v;
        logic        v;
        logic [15:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tv[$];

    initial begin
        checks = 0;
        errors = 0;
        auto_mem = 1'b1;
        rst = 1'b1;
        id_ready = 1'b1;
        im_gnt = 1'b0;
        im_rvalid = 1'b0;
        im_rdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Streaming with id_ready high.
        tv.push_back('{1, 1, 0, 16'h0, 0, 0, 16'h0, 32'h0});
        tv.push_back('{1, 1, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 1, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 1, 16'h1, 1, 1, 16'h1, 32'h2008_0005});
        tv.push_back('{0, 1, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 1, 16'h2, 1, 1, 16'h2, 32'h1000_0001});
        tv.push_back('{0, 1, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 1, 16'h3, 1, 1, 16'h3, 32'h1000_0002});
        tv.push_back('{0, 1, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 1, 16'h4, 1, 1, 16'h4, 32'h1000_0003});
        // Back-pressure after the first instruction.
        tv.push_back('{1, 0, 0, 16'h0, 0, 0, 16'h0, 32'h0});
        tv.push_back('{1, 0, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 0, 1, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 0, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 0, 0, 16'h0, 1, 1, 16'h1, 32'h2008_0005});
        tv.push_back('{0, 0, 0, 16'h0, 1, 1, 16'h1, 32'h2008_0005});
        tv.push_back('{0, 0, 0, 16'h0, 1, 1, 16'h1, 32'h2008_0005});
        tv.push_back('{0, 1, 0, 16'h0, 1, 1, 16'h1, 32'h2008_0005});
        tv.push_back('{0, 1, 1, 16'h1, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 0, 16'h0, 1, 0, 16'h0, 32'h0});
        tv.push_back('{0, 1, 1, 16'h2, 1, 1, 16'h2, 32'h1000_0001});

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].rst;
            id_ready = tv[i].rdy;
            #1;
            check($sformatf("tv%0d im_req", i), {31'b0, im_req},
                  {31'b0, tv[i].req});
            if (tv[i].req || tv[i].rst)
                check($sformatf("tv%0d im_addr", i), {16'b0, im_addr},
                      {16'b0, tv[i].addr});
            if (tv[i].chk_v) begin
                check($sformatf("tv%0d if_valid", i), {31'b0, if_valid},
                      {31'b0, tv[i].v});
                if (tv[i].v || tv[i].rst) begin
                    check($sformatf("tv%0d if_pc", i), {16'b0, if_pc},
                          {16'b0, tv[i].pc});
                    check($sformatf("tv%0d if_instr", i), if_instr,
                          tv[i].instr);
                end
            end
        end

        @(posedge clk);
        auto_mem = 1'b0;

        // Redirect while waiting for data.
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("s0 req", {31'b0, im_req}, 1);
        check("s0 addr", {16'b0, im_addr}, 32'h0);
        step(0, 1, 0, 0, 0, 1, 16'h0040);
        check("s1 req", {31'b0, im_req}, 0);
        step(0, 1, 0, 1, 32'hDEAD_0000, 0, 0);
        check("s2 req", {31'b0, im_req}, 0);
        check("s2 valid", {31'b0, if_valid}, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("s3 valid", {31'b0, if_valid}, 0);
        check("s3 req", {31'b0, im_req}, 1);
        check("s3 addr", {16'b0, im_addr}, 32'h40);
        step(0, 1, 0, 1, 32'hA5A5_0040, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("s5 valid", {31'b0, if_valid}, 1);
        check("s5 pc", {16'b0, if_pc}, 32'h41);
        check("s5 instr", if_instr, 32'hA5A5_0040);
        check("s5 addr", {16'b0, im_addr}, 32'h41);

        // Redirect coinciding with rvalid, then redirect from REQ.
        step(0, 1, 0, 1, 32'h0000_BAD0, 1, 16'h0100);
        check("s6 req", {31'b0, im_req}, 0);
        step(0, 1, 0, 0, 0, 1, 16'hFFFF);
        check("s7 valid", {31'b0, if_valid}, 0);
        check("s7 req", {31'b0, im_req}, 1);
        check("s7 addr", {16'b0, im_addr}, 32'h100);
        step(0, 1, 1, 0, 0, 0, 0);
        check("s8 addr", {16'b0, im_addr}, 32'hFFFF);
        step(0, 1, 0, 1, 32'h2009_0001, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("s10 valid", {31'b0, if_valid}, 1);
        check("s10 wrap pc", {16'b0, if_pc}, 32'h0);
        check("s10 instr", if_instr, 32'h2009_0001);
        check("s10 wrap addr", {16'b0, im_addr}, 32'h0);

        // Reset while waiting; late rvalid must be ignored.
        step(1, 1, 0, 0, 0, 0, 0);
        check("s11 req", {31'b0, im_req}, 0);
        step(0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0);
        check("s12 valid", {31'b0, if_valid}, 0);
        check("s12 pc", {16'b0, if_pc}, 32'h0);
        check("s12 instr", if_instr, 32'h0);
        check("s12 req", {31'b0, im_req}, 1);
        check("s12 addr", {16'b0, im_addr}, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        check("s12 stall", stall_cnt, 32'd0);
`endif

        // Redirect with gnt, then a second redirect inside DROP.
        step(0, 1, 1, 0, 0, 1, 16'h0020);
        check("s13 valid", {31'b0, if_valid}, 0);
        check("s13 addr", {16'b0, im_addr}, 32'h0);
        step(0, 1, 0, 0, 0, 1, 16'h0030);
        check("s14 req", {31'b0, im_req}, 0);
        step(0, 1, 0, 1, 32'h0000_BAD1, 0, 0);
        check("s15 req", {31'b0, im_req}, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check("s16 req", {31'b0, im_req}, 1);
        check("s16 addr", {16'b0, im_addr}, 32'h30);

        // Redirect from HOLD clears the slot.
        step(0, 0, 0, 1, 32'h2010_0031, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("s18 valid", {31'b0, if_valid}, 1);
        check("s18 pc", {16'b0, if_pc}, 32'h31);
        check("s18 instr", if_instr, 32'h2010_0031);
        check("s18 req", {31'b0, im_req}, 0);
        step(0, 0, 0, 0, 0, 1, 16'h0050);
        check("s19 req", {31'b0, im_req}, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("s20 valid", {31'b0, if_valid}, 0);
        check("s20 req", {31'b0, im_req}, 1);
        check("s20 addr", {16'b0, im_addr}, 32'h50);
`ifdef FETCH_STALL_CNT_EN
        check("s20 stall", stall_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
